// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: controller states, register-zero constant and
// the per-stage enable/flush bundle.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Clear wins over increment; increment stops at the maximum value.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use stalls,
// MEM-resolved branch flushes, data-memory wait handshake with timeout, and
// saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             idex_memtoreg,
    input  logic [4:0]       idex_writereg,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             pc_src,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t             state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               err_q;

    logic               mem_op;
    logic               mem_stall;
    logic               branch_taken;
    logic               load_use;
    logic               branch_apply;
    logic               pc_en_c;
    stage_ctrl_t        ifid_c;
    stage_ctrl_t        idex_c;
    stage_ctrl_t        exmem_c;

    assign mem_op       = exmem_memread | exmem_memwrite;
    assign mem_stall    = mem_op & ~dmem_ready & (state != ERR);
    assign branch_taken = exmem_branch & exmem_zero;
    assign load_use     = idex_memtoreg & (idex_writereg != REG_ZERO) &
                          ((idex_writereg == id_rs) |
                           (id_uses_rt & (idex_writereg == id_rt)));

    // Mealy control decode in priority order: reset, error, memory stall,
    // branch flush, load-use stall, normal flow.
    always_comb begin
        pc_en_c       = 1'b1;
        ifid_c        = '{en: 1'b1, flush: 1'b0};
        idex_c        = '{en: 1'b1, flush: 1'b0};
        exmem_c       = '{en: 1'b1, flush: 1'b0};
        pc_src        = 1'b0;
        memwb_bubble  = 1'b0;
        branch_apply  = 1'b0;
        dmem_req      = mem_op & (state != ERR) & ~reset;
        if (reset) begin
            ifid_c.flush  = 1'b1;
            idex_c.flush  = 1'b1;
            exmem_c.flush = 1'b1;
            memwb_bubble  = 1'b1;
        end else if ((state == ERR) || mem_stall) begin
            pc_en_c       = 1'b0;
            ifid_c.en     = 1'b0;
            idex_c.en     = 1'b0;
            exmem_c.en    = 1'b0;
            memwb_bubble  = 1'b1;
        end else if (branch_taken) begin
            pc_src        = 1'b1;
            ifid_c.flush  = 1'b1;
            idex_c.flush  = 1'b1;
            exmem_c.flush = 1'b1;
            branch_apply  = 1'b1;
        end else if (load_use) begin
            pc_en_c       = 1'b0;
            ifid_c.en     = 1'b0;
            idex_c.flush  = 1'b1;
        end
    end

    assign pc_en           = pc_en_c;
    assign ifid_en         = ifid_c.en;
    assign ifid_flush      = ifid_c.flush;
    assign idex_en         = idex_c.en;
    assign idex_flush      = idex_c.flush;
    assign exmem_en        = exmem_c.en;
    assign exmem_flush     = exmem_c.flush;
    assign mem_timeout_err = err_q;

    // Memory-wait FSM; wait_cnt counts stall cycles including the first one
    // spent in RUN, so ERR follows exactly MEM_TIMEOUT stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state    <= ERR;
                        err_q    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERR: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .inc   (~reset & ~pc_en_c),
        .clr   (reset),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .inc   (branch_apply),
        .clr   (reset),
        .count (flush_count)
    );

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It generates enable and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and forces a bubble into MEM/WB during a memory stall. It resolves load-use hazards in ID, taken branches resolved in MEM (Branch & Zero from EX/MEM), and variable-latency data-memory accesses through a ready handshake with timeout. It also keeps saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 64: MEM_WAIT cycles before the error state is entered.
- CNT_W, 32: performance counter width.

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- idex_memtoreg  in  1  load in EX
- idex_writereg  in  5  destination register of the instruction in EX
- exmem_branch, exmem_zero  in  1 each  Branch_out and Zero_out from EX/MEM
- exmem_memread, exmem_memwrite  in  1 each  memory operation in MEM
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  memory access valid
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables
- pc_src  out  1  1 = PC loads BranchTarget_out
- ifid_flush, idex_flush, exmem_flush  out  1 each  synchronous clear of the register (takes priority over its enable)
- memwb_bubble  out  1  MEM/WB loads zeros
- mem_timeout_err  out  1  sticky error flag
- stall_count, flush_count  out  CNT_W each  saturating counters

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset sets state RUN, both counters to 0, and mem_timeout_err to 0.
- mem_op = exmem_memread | exmem_memwrite. dmem_req = mem_op & (state != ERR).
- Priority order: ERR > memory stall > branch flush > load-use stall > normal.
- Memory stall: applies when mem_op & !dmem_ready in RUN or MEM_WAIT.
  - All enables go to 0 and memwb_bubble goes to 1. No flush is asserted.
  - RUN moves to MEM_WAIT.
- MEM_WAIT behaviour:
  - wait_cnt increments each cycle.
  - When dmem_ready is 1, the stall is released in that same cycle (all enables 1) and the FSM returns to RUN.
  - If wait_cnt reaches MEM_TIMEOUT-1 and dmem_ready is still 0, the FSM enters ERR.
- ERR behaviour:
  - All enables 0 and memwb_bubble 1.
  - mem_timeout_err is 1.
  - Only reset leaves ERR.
- Branch taken: applies when exmem_branch & exmem_zero and no memory stall.
  - pc_src=1, pc_en=1.
  - ifid_flush, idex_flush and exmem_flush are 1.
  - Any load-use condition in the same cycle is ignored, because the instruction is squashed.
- Load-use hazard: condition is idex_memtoreg & idex_writereg≠0 & (idex_writereg==id_rs | (id_uses_rt & idex_writereg==id_rt)).
  - pc_en=0, ifid_en=0, idex_flush=1.
  - exmem_en=1.
- Normal: all enables 1, all flushes 0, pc_src 0, memwb_bubble 0.
- Counters:
  - stall_count increments in each non-reset cycle with pc_en=0.
  - flush_count increments once per branch-taken cycle.
  - Both saturate at all-ones.
- Outputs while reset is high:
  - enables 1, all flushes 1, memwb_bubble 1.
  - pc_src 0, dmem_req 0.

## Timing
- All control outputs are combinational from the state and current inputs (Mealy), so they act on the same clock edge.
- State, wait_cnt, counters and mem_timeout_err are registered.
- Zero-wait memory (dmem_ready with the request) adds no stall cycles.
- A load-use hazard costs exactly 1 bubble.
- A taken branch costs 3 squashed slots.
- If dmem_ready rises in the first stall cycle, the total stall is 1 cycle. MEM_WAIT lasts N cycles for ready at cycle N.
- Reset during MEM_WAIT or ERR returns the FSM to RUN on the next edge.
- Counter values are visible one cycle after the counted event.

## Structure
- A shared pipeline package holds:
  - the state enum (RUN, MEM_WAIT, ERR)
  - the REG_ZERO constant (5'd0)
  - a stage-control bundle typedef {en, flush}
- Sub-module sat_counter (parameter W, inputs inc and clr) is instantiated twice for the performance counters.
- Hazard detection and the FSM live in the top module.

## Test plan
- Load-use: idex_memtoreg=1, idex_writereg=5, id_rs=5 → 1 cycle with pc_en=0, ifid_en=0, idex_flush=1; stall_count becomes 1.
- Load to $0: idex_writereg=0 and id_rs=0 → no stall.
- Branch with concurrent load-use: exmem_branch=exmem_zero=1 together with a load-use condition → pc_src=1, all three flushes 1, pc_en=1; flush_count becomes 1.
- Memory wait: exmem_memread=1, dmem_ready rising after 3 cycles → all enables 0 for 3 cycles then released on the 4th cycle; stall_count becomes 3.
- Timeout: MEM_TIMEOUT=4 with dmem_ready held at 0 → ERR entered after 4 stall cycles, then mem_timeout_err=1 held until reset.
- Reset mid-MEM_WAIT: reset asserted on the 2nd wait cycle → state RUN, counters 0, mem_timeout_err 0 on the next cycle.
